// File: rtl/ysyx_25040111_mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Arbiter states, master identifiers and the default burst-length width.
package ysyx_25040111_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_C = 2'd1,
    GNT_L = 2'd2
  } arb_state_e;

  localparam logic MST_C = 1'b0;
  localparam logic MST_L = 1'b1;

  localparam int LEN_W_DEFAULT = 8;

endpackage

// File: rtl/ysyx_25040111_rr_pick.sv
// Two-way round-robin selector.
// Bit 0 is the I-cache and bit 1 is the LSU; on contention the master that was not granted last wins.
module ysyx_25040111_rr_pick
  import ysyx_25040111_mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (last_i == MST_L) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_25040111_mem_arbiter.sv
// Shares one memory master port between the I-cache refill engine and the LSU.
// Whole transactions are granted; beats are counted to find the end of a burst.
module ysyx_25040111_mem_arbiter
  import ysyx_25040111_mem_arbiter_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             c_valid,
  input  logic [31:0]      c_addr,
  input  logic [LEN_W-1:0] c_len,
  input  logic             c_burst,
  output logic             c_ready,
  output logic [31:0]      c_data,
  input  logic             l_valid,
  input  logic             l_wen,
  input  logic [31:0]      l_addr,
  input  logic [31:0]      l_wdata,
  input  logic [3:0]       l_wmask,
  output logic             l_ready,
  output logic [31:0]      l_rdata,
  output logic             m_valid,
  output logic [31:0]      m_addr,
  output logic [LEN_W-1:0] m_len,
  output logic             m_burst,
  output logic             m_wen,
  output logic [31:0]      m_wdata,
  output logic [3:0]       m_wmask,
  input  logic             m_ready,
  input  logic [31:0]      m_rdata,
  input  logic             m_err,
  output logic             err
);

  arb_state_e       state_q;
  logic             last_q;
  logic [LEN_W-1:0] beat_left_q;
  logic [1:0]       gnt;
  logic             gnt_c;
  logic             gnt_l;

  ysyx_25040111_rr_pick u_rr_pick (
    .req_i  ({l_valid, c_valid}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign gnt_c = (state_q == GNT_C);
  assign gnt_l = (state_q == GNT_L);

  // Arbitration only happens in IDLE, which also gives the bubble after every transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= MST_L;
      beat_left_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt[0]) begin
            state_q     <= GNT_C;
            last_q      <= MST_C;
            beat_left_q <= c_len;
          end else if (gnt[1]) begin
            state_q     <= GNT_L;
            last_q      <= MST_L;
            beat_left_q <= '0;
          end
        end
        GNT_C, GNT_L: begin
          if (m_err) begin
            state_q     <= IDLE;
            beat_left_q <= '0;
          end else if (m_ready) begin
            if (beat_left_q == '0) begin
              state_q <= IDLE;
            end else begin
              beat_left_q <= beat_left_q - {{(LEN_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          beat_left_q <= '0;
        end
      endcase
    end
  end

  // The memory request is a plain mux of the granted master; everything is zero in IDLE.
  always_comb begin
    m_valid = 1'b0;
    m_addr  = '0;
    m_len   = '0;
    m_burst = 1'b0;
    m_wen   = 1'b0;
    m_wdata = '0;
    m_wmask = '0;
    if (gnt_c) begin
      m_valid = c_valid;
      m_addr  = c_addr;
      m_len   = c_len;
      m_burst = c_burst;
    end else if (gnt_l) begin
      m_valid = l_valid;
      m_addr  = l_addr;
      m_wen   = l_wen;
      m_wdata = l_wdata;
      m_wmask = l_wmask;
    end
  end

  // An error in the same cycle as a beat suppresses that beat's ready.
  assign c_ready = m_ready & ~m_err & gnt_c;
  assign l_ready = m_ready & ~m_err & gnt_l;
  assign err     = m_err & (gnt_c | gnt_l);
  assign c_data  = m_rdata;
  assign l_rdata = m_rdata;

endmodule

// File: tb/tb_ysyx_25040111_mem_arbiter.sv
// Directed bench for the memory arbiter; expected master responses are queued
// by the stimulus and consumed by a negedge monitor.
module tb_ysyx_25040111_mem_arbiter;

  localparam int LEN_W = 8;
  localparam logic [2:0] K_C   = 3'b100;
  localparam logic [2:0] K_L   = 3'b010;
  localparam logic [2:0] K_ERR = 3'b001;

  logic             clock;
  logic             reset;
  logic             c_valid;
  logic [31:0]      c_addr;
  logic [LEN_W-1:0] c_len;
  logic             c_burst;
  logic             c_ready;
  logic [31:0]      c_data;
  logic             l_valid;
  logic             l_wen;
  logic [31:0]      l_addr;
  logic [31:0]      l_wdata;
  logic [3:0]       l_wmask;
  logic             l_ready;
  logic [31:0]      l_rdata;
  logic             m_valid;
  logic [31:0]      m_addr;
  logic [LEN_W-1:0] m_len;
  logic             m_burst;
  logic             m_wen;
  logic [31:0]      m_wdata;
  logic [3:0]       m_wmask;
  logic             m_ready;
  logic [31:0]      m_rdata;
  logic             m_err;
  logic             err;

  typedef struct packed {
    logic [2:0]  flags;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;

  ysyx_25040111_mem_arbiter #(.LEN_W(LEN_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .c_valid (c_valid),
    .c_addr  (c_addr),
    .c_len   (c_len),
    .c_burst (c_burst),
    .c_ready (c_ready),
    .c_data  (c_data),
    .l_valid (l_valid),
    .l_wen   (l_wen),
    .l_addr  (l_addr),
    .l_wdata (l_wdata),
    .l_wmask (l_wmask),
    .l_ready (l_ready),
    .l_rdata (l_rdata),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_len   (m_len),
    .m_burst (m_burst),
    .m_wen   (m_wen),
    .m_wdata (m_wdata),
    .m_wmask (m_wmask),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .m_err   (m_err),
    .err     (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every ready or error pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    logic [2:0]  actFlags;
    logic [31:0] actData;
    actFlags = {c_ready, l_ready, err};
    if (actFlags != 3'b000) begin
      actData = c_ready ? c_data : l_rdata;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_response: got flags %b data %h expected none", actFlags, actData);
      end else begin
        monExp = expQ.pop_front();
        if (actFlags != monExp.flags || (monExp.flags != K_ERR && actData != monExp.data)) begin
          errors++;
          $display("[TB] FAIL response: got flags %b data %h expected flags %b data %h",
                   actFlags, actData, monExp.flags, monExp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] kind, input logic [31:0] data, input logic withErr);
    m_ready = 1'b1;
    m_rdata = data;
    m_err   = withErr;
    expQ.push_back('{flags: withErr ? K_ERR : kind, data: data});
    tick();
    m_ready = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic checkIdle(input string name);
    @(negedge clock);
    checkOutput({name, "_m_valid"}, 32'(m_valid), 32'h0);
    checkOutput({name, "_m_addr"}, m_addr, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    c_valid = 0; c_addr = 0; c_len = 0; c_burst = 0;
    l_valid = 0; l_wen = 0; l_addr = 0; l_wdata = 0; l_wmask = 0;
    m_ready = 0; m_rdata = 0; m_err = 0;
    tick();
    tick();
    @(negedge clock);
    checkOutput("reset_m_valid", 32'(m_valid), 32'h0);
    checkOutput("reset_ready_err", 32'({c_ready, l_ready, err}), 32'h0);
    checkOutput("reset_m_wmask", 32'(m_wmask), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // I-cache 4-beat refill
    c_valid = 1; c_addr = 32'h3000_0010; c_len = 8'd3; c_burst = 1;
    @(negedge clock);
    checkOutput("grant_latency_m_valid", 32'(m_valid), 32'h0);
    tick();
    @(negedge clock);
    checkOutput("c_m_valid", 32'(m_valid), 32'h1);
    checkOutput("c_m_addr", m_addr, 32'h3000_0010);
    checkOutput("c_m_len", 32'(m_len), 32'd3);
    checkOutput("c_m_burst", 32'(m_burst), 32'h1);
    checkOutput("c_m_wen_wmask", 32'({m_wen, m_wmask}), 32'h0);
    tick();
    applyStimulus(K_C, 32'h11, 0);
    applyStimulus(K_C, 32'h22, 0);
    applyStimulus(K_C, 32'h33, 0);
    applyStimulus(K_C, 32'h44, 0);
    checkIdle("c_bubble");
    c_valid = 0; c_burst = 0;
    tick();

    // LSU store
    l_valid = 1; l_wen = 1; l_addr = 32'h8000_0004; l_wdata = 32'hDEAD_BEEF; l_wmask = 4'b0011;
    tick();
    @(negedge clock);
    checkOutput("l_m_valid", 32'(m_valid), 32'h1);
    checkOutput("l_m_addr", m_addr, 32'h8000_0004);
    checkOutput("l_m_wdata", m_wdata, 32'hDEAD_BEEF);
    checkOutput("l_m_wen_wmask", 32'({m_wen, m_wmask}), 32'h13);
    checkOutput("l_m_len_burst", 32'({m_len, m_burst}), 32'h0);
    tick();
    applyStimulus(K_L, 32'h0, 0);
    checkIdle("l_bubble");
    l_valid = 0; l_wen = 0;
    tick();

    // Contention from reset: I-cache, then LSU, then I-cache again
    reset = 1; tick(); reset = 0;
    c_valid = 1; c_addr = 32'h3000_0100; c_len = 0;
    l_valid = 1; l_addr = 32'h8000_0200; l_wdata = 0; l_wmask = 0;
    tick();
    @(negedge clock);
    checkOutput("rr1_m_addr", m_addr, 32'h3000_0100);
    tick();
    applyStimulus(K_C, 32'hA1, 0);
    c_valid = 0;
    checkIdle("rr_bubble");
    tick();
    @(negedge clock);
    checkOutput("rr2_m_addr", m_addr, 32'h8000_0200);
    checkOutput("rr2_m_wen", 32'(m_wen), 32'h0);
    tick();
    applyStimulus(K_L, 32'hB2, 0);
    c_valid = 1;
    tick();
    @(negedge clock);
    checkOutput("rr3_m_addr", m_addr, 32'h3000_0100);
    tick();
    applyStimulus(K_C, 32'hC3, 0);
    c_valid = 0; l_valid = 0;
    tick();

    // Bus error on beat 2 of a refill, LSU served afterwards
    c_valid = 1; c_addr = 32'h3000_0400; c_len = 8'd3;
    tick();
    l_valid = 1; l_wen = 1; l_addr = 32'h8000_0008; l_wdata = 32'h1234_5678; l_wmask = 4'hF;
    applyStimulus(K_C, 32'h55, 0);
    applyStimulus(K_C, 32'h66, 1);
    c_valid = 0;
    checkIdle("err_idle");
    tick();
    @(negedge clock);
    checkOutput("err_l_m_addr", m_addr, 32'h8000_0008);
    checkOutput("err_l_m_wen", 32'(m_wen), 32'h1);
    tick();
    applyStimulus(K_L, 32'h0, 0);
    l_valid = 0; l_wen = 0;
    tick();

    // Reset mid-burst, then a fresh full burst
    c_valid = 1; c_addr = 32'h3000_0800; c_len = 8'd3;
    tick();
    applyStimulus(K_C, 32'h61, 0);
    reset = 1;
    tick();
    reset = 0;
    m_ready = 1;
    @(negedge clock);
    checkOutput("rst_mid_m_valid", 32'(m_valid), 32'h0);
    checkOutput("rst_mid_c_ready", 32'(c_ready), 32'h0);
    tick();
    m_ready = 0;
    @(negedge clock);
    checkOutput("rst_regrant_m_addr", m_addr, 32'h3000_0800);
    tick();
    for (int i = 1; i <= 4; i++) applyStimulus(K_C, 32'h70 + 32'(i), 0);
    checkIdle("rst_burst_bubble");
    c_valid = 0;
    tick();

    // Maximum-length burst: 256 beats
    c_valid = 1; c_addr = 32'h3000_1000; c_len = 8'd255;
    tick();
    @(negedge clock);
    checkOutput("long_m_len", 32'(m_len), 32'd255);
    tick();
    for (int i = 0; i < 256; i++) applyStimulus(K_C, 32'h1000 + 32'(i), 0);
    checkIdle("long_release");
    c_valid = 0;
    tick();
    m_ready = 1;
    @(negedge clock);
    checkOutput("idle_no_ready", 32'({c_ready, l_ready}), 32'h0);
    tick();
    m_ready = 0;
    tick();

    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25040111_mem_arbiter.md
# ysyx_25040111_mem_arbiter

Two-master, one-slave arbiter that shares the core's single memory master port between the instruction-cache refill engine and the LSU. It sits between the I-cache refill interface (valid/ready beats, burst length, burst flag) plus the LSU load/store interface on one side, and the SoC/simulation memory bridge on the other. It grants whole transactions, counts beats to find the end of a burst, alternates round-robin between masters, and routes ready, read data and error back to the granted master only.

## Interface
Parameters:
- `LEN_W`, 8, width of the burst-length field (beats − 1).

Ports (clock and reset first):
- `clock`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `c_valid`  in  1  I-cache refill request; held until its last beat completes.
- `c_addr`  in  32  I-cache refill address.
- `c_len`  in  LEN_W  I-cache beats − 1.
- `c_burst`  in  1  I-cache burst flag, passed through.
- `c_ready`  out  1  per-beat completion to I-cache.
- `c_data`  out  32  read data to I-cache, valid when `c_ready`.
- `l_valid`  in  1  LSU request; held until completion.
- `l_wen`  in  1  LSU write enable.
- `l_addr`  in  32  LSU address.
- `l_wdata`  in  32  LSU write data.
- `l_wmask`  in  4  LSU byte strobes.
- `l_ready`  out  1  LSU completion (single beat).
- `l_rdata`  out  32  read data to LSU, valid when `l_ready`.
- `m_valid`  out  1  request to memory bridge.
- `m_addr`  out  32  address to memory.
- `m_len`  out  LEN_W  beats − 1 (0 for LSU).
- `m_burst`  out  1  burst flag (0 for LSU).
- `m_wen`  out  1  write enable (0 for I-cache).
- `m_wdata`  out  32  write data.
- `m_wmask`  out  4  byte strobes (0 for I-cache).
- `m_ready`  in  1  one beat complete.
- `m_rdata`  in  32  beat read data.
- `m_err`  in  1  bus error for the current transaction.
- `err`  out  1  error, forwarded for one cycle to the granted master.

## Operation
- States: `IDLE`, `GNT_C`, `GNT_L`. Registered `last` bit records the last granted master; reset value = LSU, so I-cache wins the first contention.
- `IDLE`: only `c_valid` → `GNT_C`; only `l_valid` → `GNT_L`; both → master other than `last`. Neither → stay.
- On entering a grant: latch `len` from the requester into `beat_left`; set `last`.
- `GNT_x`: `m_*` request fields are a pure mux of master x's inputs; `m_valid = x_valid`. Each `m_ready` decrements `beat_left`; `m_ready` with `beat_left == 0` ends the transaction → `IDLE`.
- `c_ready = m_ready & GNT_C`; `l_ready = m_ready & GNT_L`; `c_data`/`l_rdata` = `m_rdata` (ungated; qualified by ready).
- `m_err` in a grant state: `err` = 1 for that cycle, ready not asserted, state → `IDLE` immediately; `beat_left` cleared.
- Requester dropping valid mid-grant: grant retained, `m_valid` deasserts; the arbiter does not abort. Requester must reassert.
- In `IDLE` all `m_*` outputs = 0.
- Reset values: `m_valid`, `m_addr`, `m_len`, `m_burst`, `m_wen`, `m_wdata`, `m_wmask`, `c_ready`, `l_ready`, `err` = 0; state `IDLE`; `beat_left` = 0.

## Timing
- Grant latency: request visible in `IDLE` at cycle N → `m_valid` high at N+1 (registered state).
- Beats combinationally forwarded; zero added latency on ready/data.
- One mandatory `IDLE` bubble after every transaction end or error; arbitration happens in that cycle.
- `beat_left` width LEN_W; `c_len = 255` gives 256 beats; no wrap (decrement stops at end condition).
- `m_ready` and `m_err` in the same cycle: error wins, no ready forwarded.
- Reset asserted mid-burst: next cycle state `IDLE`, all outputs 0, in-flight beats dropped.

## Structure
- Shared package: state encoding (`IDLE`, `GNT_C`, `GNT_L`), master-id constants, `LEN_W` default.
- One sub-module natural: `ysyx_25040111_rr_pick` — 2-way round-robin selector (requests, `last`) → grant one-hot. Remainder (FSM, beat counter, muxes) stays in this module.

## Test plan
- I-cache only, `c_len=3`, `c_addr=0x3000_0010`, memory returns 0x11..0x44 → `m_valid` at N+1, four `c_ready` pulses with matching `c_data`, `IDLE` after 4th beat.
- LSU store, `l_addr=0x8000_0004`, `l_wdata=0xDEADBEEF`, `l_wmask=4'b0011` → `m_wen=1`, `m_len=0`, `m_burst=0`, one `l_ready`, `c_ready` stays 0.
- Both request from reset → I-cache granted first; LSU granted after one bubble cycle; then both again → I-cache (alternation).
- `m_err` on beat 2 of a 4-beat refill → `err` pulse, no `c_ready` that cycle, state `IDLE` next cycle, LSU then served.
- `reset` mid-burst after beat 1 → all outputs 0 next cycle; fresh `c_valid` then gets full 4-beat burst counted from zero.
- `c_len=255` burst → exactly 256 `c_ready` pulses, release after the 256th.
